// File: rtl/date_pkg.sv
// date_pkg: shared widths, mode encoding and month-length constants for the date counter
package date_pkg;
  localparam int DAY_W = 5;
  localparam int MON_W = 4;
  typedef enum logic [1:0] {RUN = 2'd0, SET_YEAR = 2'd1, SET_MONTH = 2'd2, SET_DAY = 2'd3} mode_t;
  localparam logic [DAY_W-1:0] LEN_31 = 5'd31;
  localparam logic [DAY_W-1:0] LEN_30 = 5'd30;
  localparam logic [DAY_W-1:0] LEN_FEB = 5'd28;
  localparam logic [DAY_W-1:0] LEN_FEB_LEAP = 5'd29;
endpackage

// File: rtl/date_countdown_if.sv
// date_countdown_if: pulse inputs and date/mode outputs of the date counter
interface date_countdown_if import date_pkg::*; #(parameter int YEAR_W = 12);
  logic bin;
  logic set;
  logic inc;
  logic [DAY_W-1:0] day;
  logic [MON_W-1:0] month;
  logic [YEAR_W-1:0] year;
  logic [1:0] mode;
  logic bout;
  modport master(output bin, set, inc, input day, month, year, mode, bout);
  modport slave(input bin, set, inc, output day, month, year, mode, bout);
endinterface

// File: rtl/month_len.sv
// month_len: days in a month; February is 29 in years divisible by 4 when LEAP_YEAR_EN is defined
module month_len import date_pkg::*; (
  input  logic [MON_W-1:0] month,
  input  logic [1:0]       yr,
  output logic [DAY_W-1:0] days
);
  logic [DAY_W-1:0] feb;
`ifdef LEAP_YEAR_EN
  assign feb = yr == 2'd0 ? LEN_FEB_LEAP : LEN_FEB;
`else
  logic unused_yr;
  assign unused_yr = ^yr;
  assign feb = LEN_FEB;
`endif
  always_comb
    days = month == 4'd2 ? feb :
           (month == 4'd4 || month == 4'd6 || month == 4'd9 || month == 4'd11) ? LEN_30 : LEN_31;
endmodule

// File: rtl/date_countdown.sv
// date_countdown: day/month/year down-counter with borrow chain and set mode (LEAP_YEAR_EN enables leap Feb)
module date_countdown import date_pkg::*; #(
  parameter int YEAR_W   = 12,
  parameter int YEAR_MIN = 2000,
  parameter int YEAR_MAX = 2099
) (
  input logic clk,
  input logic rst,
  date_countdown_if.slave d
);
  localparam logic [YEAR_W-1:0] YMIN = YEAR_W'(YEAR_MIN);
  localparam logic [YEAR_W-1:0] YMAX = YEAR_W'(YEAR_MAX);
  logic [DAY_W-1:0] day, day_n, len_dec, len_c;
  logic [MON_W-1:0] month, month_n, m_inc, m_dec, cm;
  logic [YEAR_W-1:0] year, year_n, y_inc, cy;
  logic [1:0] mode, mode_n;
  logic first, dec, bump;
  assign first = day == 5'd1 && month == 4'd1 && year == YMIN;
  assign dec = mode == RUN && d.bin;
  assign bump = mode != RUN && d.inc && !d.set;
  assign y_inc = year == YMAX ? YMIN : year + YEAR_W'(1);
  assign m_inc = month == 4'd12 ? 4'd1 : month + 4'd1;
  assign m_dec = month - 4'd1;
  // clamp lookup sees the field as it will be after the increment; in SET_DAY it is the current length
  assign cm = mode == SET_MONTH ? m_inc : month;
  assign cy = mode == SET_YEAR ? y_inc : year;
  month_len u_dec (.month(m_dec), .yr(year[1:0]), .days(len_dec));
  month_len u_clamp (.month(cm), .yr(cy[1:0]), .days(len_c));
  always_comb begin
    mode_n = d.set ? mode + 2'd1 : mode;
    day_n = day;
    month_n = month;
    year_n = year;
    if (dec) begin
      day_n = day != 5'd1 ? day - 5'd1 : month != 4'd1 ? len_dec : LEN_31;
      month_n = day != 5'd1 ? month : month != 4'd1 ? m_dec : 4'd12;
      year_n = day != 5'd1 || month != 4'd1 ? year : first ? YMAX : year - YEAR_W'(1);
    end else if (bump) begin
      year_n = cy;
      month_n = cm;
      day_n = mode == SET_DAY ? (day == len_c ? 5'd1 : day + 5'd1) : (day > len_c ? len_c : day);
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      day <= LEN_31;
      month <= 4'd12;
      year <= YMAX;
      mode <= RUN;
    end else begin
      day <= day_n;
      month <= month_n;
      year <= year_n;
      mode <= mode_n;
    end
  assign d.day = day;
  assign d.month = month;
  assign d.year = year;
  assign d.mode = mode;
  assign d.bout = dec && first && !rst;
endmodule

// File: tb/tb_date_countdown.sv
// tb_date_countdown: randomized scoreboard bench for date_countdown against a calendar model
module tb_date_countdown;
  import date_pkg::*;
  localparam int YMIN = 2000;
  localparam int YMAX = 2099;
  typedef struct {int d; int m; int y; int mo;} st_t;
  logic clk = 0;
  logic rst;
  int checks = 0;
  int failures = 0;
  int md, mm, my, mmode;
  st_t sq[$];
  int bq[$];
  always #5 clk = ~clk;
  date_countdown_if #(.YEAR_W(12)) dif();
  date_countdown #(.YEAR_W(12), .YEAR_MIN(YMIN), .YEAR_MAX(YMAX)) dut (.clk(clk), .rst(rst), .d(dif));
  function automatic int len(input int m, input int y);
    int feb;
`ifdef LEAP_YEAR_EN
    feb = (y % 4 == 0) ? 29 : 28;
`else
    feb = 28;
`endif
    if (m == 2) return feb;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic cyc(input bit r, input bit b, input bit s, input bit i);
    st_t e;
    @(negedge clk);
    rst = r;
    dif.bin = b;
    dif.set = s;
    dif.inc = i;
    bq.push_back((!r && mmode == 0 && b && md == 1 && mm == 1 && my == YMIN) ? 1 : 0);
    if (r) begin
      md = 31; mm = 12; my = YMAX; mmode = 0;
    end else begin
      if (mmode == 0 && b) begin
        md--;
        if (md == 0) begin
          mm--;
          if (mm == 0) begin
            mm = 12;
            my = (my == YMIN) ? YMAX : my - 1;
          end
          md = len(mm, my);
        end
      end else if (mmode != 0 && i && !s) begin
        if (mmode == 1) my = (my == YMAX) ? YMIN : my + 1;
        if (mmode == 2) mm = mm % 12 + 1;
        if (mmode == 3) md = (md == len(mm, my)) ? 1 : md + 1;
        else if (md > len(mm, my)) md = len(mm, my);
      end
      if (s) mmode = (mmode + 1) % 4;
    end
    e.d = md; e.m = mm; e.y = my; e.mo = mmode;
    sq.push_back(e);
  endtask
  task automatic goto_mode(input int k);
    for (int n = 0; n < 4 && mmode != k; n++) cyc(0, 0, 1, 0);
  endtask
  task automatic load(input int d, input int m, input int y);
    goto_mode(1);
    for (int n = 0; n < 200 && my != y; n++) cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    for (int n = 0; n < 20 && mm != m; n++) cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    for (int n = 0; n < 40 && md != d; n++) cyc(0, 0, 0, 1);
  endtask
  initial forever begin
    st_t e;
    @(posedge clk);
    #1;
    if (sq.size() > 0) begin
      e = sq.pop_front();
      chk("day", 32'(dif.day), e.d);
      chk("month", 32'(dif.month), e.m);
      chk("year", 32'(dif.year), e.y);
      chk("mode", 32'(dif.mode), e.mo);
    end
  end
  initial forever begin
    int eb;
    @(negedge clk);
    #2;
    if (bq.size() > 0) begin
      eb = bq.pop_front();
      chk("bout", 32'(dif.bout), eb);
    end
  end
  initial begin
    rst = 1; dif.bin = 0; dif.set = 0; dif.inc = 0;
    md = 31; mm = 12; my = YMAX; mmode = 0;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    load(1, 3, 2024);
    goto_mode(0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    load(1, 1, 2000);
    goto_mode(0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    load(31, 1, 2023);
    goto_mode(2);
    cyc(0, 0, 0, 1);
    load(31, 3, 2023);
    goto_mode(2);
    cyc(0, 0, 0, 1);
    goto_mode(3);
    cyc(0, 0, 1, 1);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0);
    goto_mode(3);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 0);
    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 1) == 1);
    load(3, 1, 2000);
    goto_mode(0);
    for (int n = 0; n < 5; n++) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
